// File: rtl/divider_pkg.sv
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared types and defaults for the sequential unsigned divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_pkg;

  // Controller states of the iterative divider
  typedef enum logic {IDLE, RUN} div_state_t;

  // Operand width used when the instantiating code does not override it
  localparam int DIV_WIDTH_DEFAULT = 4;

endpackage : divider_pkg

`default_nettype wire

// File: rtl/divider_step.sv
// ============================================================================
//  Module      : divider_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder, trial-subtracts the
//                divisor and keeps the difference when it is non-negative.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_div_ext;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // The partial remainder is always below the divisor after a step, so its
  // top bit carries no information and is discarded by the shift.
  logic           w_unused_rem_msb;
  assign w_unused_rem_msb = rem[WIDTH];

  assign w_shift   = {rem[WIDTH-1:0], q_msb};
  assign w_div_ext = {1'b0, divisor};
  assign w_ge      = (w_shift >= w_div_ext);
  assign w_diff    = w_shift - w_div_ext;

  assign rem_next  = w_ge ? w_diff : w_shift;
  assign q_bit     = w_ge;

endmodule : divider_step

`default_nettype wire

// File: rtl/seq_unsigned_divider.sv
// ============================================================================
//  Module      : seq_unsigned_divider
//  Description : Iterative unsigned restoring divider, one quotient bit per
//                clock, start/busy/done handshake. Divide by zero yields
//                quotient all ones and remainder = dividend.
//                Optional macro DIVIDER_ZERO_DETECT_EN: a zero divisor is
//                caught at start and the result is returned after one cycle
//                with div_by_zero asserted alongside done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_unsigned_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int         c_CNT_W   = $clog2(WIDTH + 1);
  localparam logic [0:0] c_ST_IDLE = IDLE;
  localparam logic [0:0] c_ST_RUN  = RUN;

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_done;

  logic [WIDTH:0]     w_rem_next;
  logic               w_q_bit;
  logic [WIDTH-1:0]   w_q_next;

  divider_step #(
    .WIDTH    (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .q_msb    (r_q[WIDTH-1]),
    .divisor  (r_divisor),
    .rem_next (w_rem_next),
    .q_bit    (w_q_bit)
  );

  assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

`ifdef DIVIDER_ZERO_DETECT_EN
  logic r_zero;
  logic r_dbz;

  // Sequencer: load on start, one restoring step per clock, publish on the
  // last step; a zero divisor bypasses the iteration entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_divisor <= divisor;
            r_rem     <= '0;
            r_q       <= dividend;
            r_state   <= c_ST_RUN;
            if (divisor == '0) begin
              // Result is known immediately; spend one cycle before done.
              r_zero      <= 1'b1;
              r_cnt       <= '0;
              r_quotient  <= '1;
              r_remainder <= dividend;
            end else begin
              r_zero <= 1'b0;
              r_cnt  <= c_CNT_W'(WIDTH);
            end
          end
        end
        c_ST_RUN: begin
          if (r_zero) begin
            r_zero  <= 1'b0;
            r_done  <= 1'b1;
            r_dbz   <= 1'b1;
            r_state <= c_ST_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) begin
              r_quotient  <= w_q_next;
              r_remainder <= w_rem_next[WIDTH-1:0];
              r_done      <= 1'b1;
              r_dbz       <= 1'b0;
              r_state     <= c_ST_IDLE;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign div_by_zero = r_dbz;
`else
  // Sequencer: load on start, one restoring step per clock, publish on the
  // last step; a zero divisor simply runs the full iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_divisor <= divisor;
            r_rem     <= '0;
            r_q       <= dividend;
            r_cnt     <= c_CNT_W'(WIDTH);
            r_state   <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - c_CNT_W'(1);
          if (r_cnt == c_CNT_W'(1)) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next[WIDTH-1:0];
            r_done      <= 1'b1;
            r_state     <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign div_by_zero = 1'b0;
`endif

  assign busy      = (r_state == c_ST_RUN);
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule : seq_unsigned_divider

`default_nettype wire

// File: tb/tb_seq_unsigned_divider.sv
// ============================================================================
//  Module      : tb_seq_unsigned_divider
//  Description : Scoreboard bench for seq_unsigned_divider (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_unsigned_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_unsigned_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int e0;
    int lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer division; divide by zero gives all ones / dividend
  function automatic exp_t model(input int a, input int b, input int e0);
    exp_t e;
    e.a = a;
    e.b = b;
    e.e0 = e0;
    if (b == 0) begin
      e.q = (1 << W) - 1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`ifdef DIVIDER_ZERO_DETECT_EN
    e.dbz = (b == 0) ? 1 : 0;
    e.lat = (b == 0) ? 1 : W;
`else
    e.dbz = 0;
    e.lat = W;
`endif
    return e;
  endfunction

  // Monitor: checks each done against the scoreboard, and holds otherwise
  int   last_q = 0;
  int   last_r = 0;
  int   last_dbz = 0;
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      last_q = 0;
      last_r = 0;
      last_dbz = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        me = sb.pop_front();
        chk("quotient", int'(quotient), me.q);
        chk("remainder", int'(remainder), me.r);
        chk("div_by_zero", int'(div_by_zero), me.dbz);
        chk("latency", cyc - me.e0, me.lat);
        chk("busy_at_done", int'(busy), 0);
        if (me.b != 0)
          chk("mult_xcheck", int'(quotient) * me.b + int'(remainder), me.a);
        last_q = me.q;
        last_r = me.r;
        last_dbz = me.dbz;
      end
    end else begin
      chk("hold_q", int'(quotient), last_q);
      chk("hold_r", int'(remainder), last_r);
      chk("hold_dbz", int'(div_by_zero), last_dbz);
    end
  end

  // Called at a negedge; the request is accepted only if the divider is idle
  task automatic issue(input int a, input int b);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    if (!busy) sb.push_back(model(a, b, cyc + 1));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=1 expected 0 within 100 cycles");
    end
  endtask

  int ta[5] = '{15, 0, 9, 8, 7};
  int tb[5] = '{15, 13, 5, 1, 15};

  initial begin
    int n;
    #1 rst = 1'b1;
    #1;
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);

    // Basic case
    issue(13, 3);
    wait_idle();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i]);
      wait_idle();
    end

    // Divide by zero
    issue(9, 0);
    wait_idle();

    // start while busy is ignored; then back-to-back in the done cycle
    issue(12, 5);
    @(negedge clk);
    issue(15, 1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
    issue(15, 1);
    wait_idle();

    // Reset in the middle of a run
    issue(10, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(6, 2);
    wait_idle();

    // Exhaustive sweep, back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        wait_idle();
        issue(a, b);
      end
    end

    // Random traffic with random gaps and requests while busy
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) != 0) wait_idle();
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    @(negedge clk);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_seq_unsigned_divider

`default_nettype wire
